e_exc_unit: RTL
===============

// Module: e_exc_unit
// PURPOSE
//   Parametrised E-stage exception unit; successor to the single-width add/sub overflow check.
//   Detects ADD/SUB overflow and load/store address faults.
//   Merges these with upstream exception state and registers the result into the E->M pipeline slot.
//   Registered output obeys stall/flush. A saturating overflow event counter feeds CP0 debug.
// PARAMETERS
//   DATA_W    32          operand/address width
//   CODE_W    5           ExcCode width
//   CNT_W     8           overflow event counter width
//   OV_CODE   12          ExcCode for arithmetic overflow (Ov)
//   ADEL_CODE 4           ExcCode for load address fault
//   ADES_CODE 5           ExcCode for store address fault
//   DM_LO     32'h0000    lowest legal data address (inclusive)
//   DM_HI     32'h2FFF    highest legal data address (inclusive)
// PORTS
//   clk        in   1       clock
//   reset      in   1       synchronous, active-high reset
//   stall      in   1       hold E->M register
//   flush      in   1       clear E->M register (exception/eret flush)
//   in_exc     in   1       upstream (F/D) exception already pending
//   in_code    in   CODE_W  upstream ExcCode
//   in_pc      in   DATA_W  PC of the E-stage instruction
//   in_bd      in   1       E-stage instruction sits in a branch delay slot
//   alu_a      in   DATA_W  operand A (rs, or base for load/store)
//   alu_b      in   DATA_W  operand B (rt/imm, or offset)
//   det_type   in   3       0 none, 1 add, 2 sub, 3 load, 4 store; 5-7 = none
//   acc_size   in   2       0 byte, 1 half, 2 word (load/store only)
//   cnt_clr    in   1       clear overflow counter
//   e_exc      out  1       combinational exception flag of current E instruction
//   m_exc      out  1       registered exception flag (M stage)
//   m_code     out  CODE_W  registered ExcCode
//   m_ovf      out  1       registered: cause was ADD/SUB overflow
//   m_pc       out  DATA_W  registered PC
//   m_bd       out  1       registered branch delay flag
//   ovf_cnt    out  CNT_W   saturating count of committed overflows
// BEHAVIOUR
//   Arithmetic (combinational):
//     - sum = sign-extended {a[W-1],a} +/- {b[W-1],b} on W+1 bits.
//     - ovf = sum[W] != sum[W-1]. The same rule applies to sub; the overflow flag is set for both add and sub.
//   Address (det_type 3/4):
//     - ea = a + b, overflow checked by the same rule (addr_ovf).
//     - Fault if any of:
//       - addr_ovf
//       - ea < DM_LO or ea > DM_HI (unsigned)
//       - acc_size=1 with ea[0]
//       - acc_size=2 with ea[1:0]!=0
//       - acc_size=3 (any address)
//     - Load fault -> ADEL_CODE; store fault -> ADES_CODE. m_ovf=0 for address faults.
//   Priority (single cause):
//     - in_exc (pass in_code unchanged) > arithmetic overflow > address fault > none.
//     - No exception: code field = 0.
//   e_exc: combinational OR of all three causes, same cycle, no latency.
//   Register update, per rising clk, first match wins:
//     1. reset: m_exc=0, m_code=0, m_ovf=0, m_pc=0, m_bd=0, ovf_cnt=0.
//     2. flush: m_exc/m_code/m_ovf/m_pc/m_bd cleared to 0. Flush beats stall.
//     3. stall: all M outputs hold.
//     4. otherwise: load merged result, in_pc and in_bd. Latency 1 cycle.
//   Counter:
//     - Commit event = case 4 with merged cause == overflow. Flush, stall or in_exc suppress it.
//     - cnt_clr sets ovf_cnt to 0 and overrides an increment in the same cycle.
//     - Saturates at 2^CNT_W-1 and never wraps.
//     - reset overrides everything.
//   Reset mid-stall or mid-flush: reset wins, all outputs are 0 on the next cycle.
//   Outputs never go X; det_type 5-7 behaves as none.
// TESTING
//   - add 7FFFFFFF+1 -> e_exc=1 same cycle; next cycle m_exc=1, m_code=12, m_ovf=1, ovf_cnt=1.
//   - sub 80000000-1 -> m_exc=1, m_code=12, m_ovf=1.
//     sub 5-3 -> m_exc=0, m_code=0.
//   - load word ea=0x1002 -> m_code=4, m_ovf=0.
//     store half ea=0x3000 -> m_code=5.
//     load byte ea=0x2FFF -> no exception.
//   - in_exc=1 with in_code=10 plus overflowing add -> m_code=10, m_ovf=0, ovf_cnt unchanged.
//   - Overflow with stall=1 for 3 cycles -> M outputs hold, no increment; the increment follows the release cycle.
//     Overflow with stall=1 and flush=1 -> M cleared, ovf_cnt unchanged.
//   - 300 committed overflows with CNT_W=8 -> ovf_cnt=255.
//     cnt_clr together with an overflow -> ovf_cnt=0.
//     Reset asserted mid-sequence -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/e_exc_unit.sv
// rtl/e_exc_unit.sv - E-stage exception unit: overflow/address-fault detect, merge, E->M register
// Detects ADD/SUB overflow and load/store address faults, merges with upstream state, counts committed overflows.
module e_exc_unit #(
    parameter int                DATA_W    = 32,
    parameter int                CODE_W    = 5,
    parameter int                CNT_W     = 8,
    parameter logic [CODE_W-1:0] OV_CODE   = 12,
    parameter logic [CODE_W-1:0] ADEL_CODE = 4,
    parameter logic [CODE_W-1:0] ADES_CODE = 5,
    parameter logic [DATA_W-1:0] DM_LO     = 'h0000,
    parameter logic [DATA_W-1:0] DM_HI     = 'h2FFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_exc,
    input  logic [CODE_W-1:0] in_code,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              in_bd,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    input  logic [2:0]        det_type,
    input  logic [1:0]        acc_size,
    input  logic              cnt_clr,
    output logic              e_exc,
    output logic              m_exc,
    output logic [CODE_W-1:0] m_code,
    output logic              m_ovf,
    output logic [DATA_W-1:0] m_pc,
    output logic              m_bd,
    output logic [CNT_W-1:0]  ovf_cnt
);

    typedef enum logic [2:0] {
        DET_NONE  = 3'd0,
        DET_ADD   = 3'd1,
        DET_SUB   = 3'd2,
        DET_LOAD  = 3'd3,
        DET_STORE = 3'd4
    } det_t;

    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   dif_ext;
    logic              add_ovf;
    logic              sub_ovf;
    logic [DATA_W-1:0] ea;
    logic              is_load;
    logic              is_store;
    logic              below_lo;
    logic              above_hi;
    logic              misaligned;
    logic              arith_ovf;
    logic              addr_fault;
    logic              merged_exc;
    logic [CODE_W-1:0] merged_code;
    logic              merged_ovf;
    logic              commit_ovf;

    // One extra sign bit: overflow shows up as the top two bits disagreeing.
    assign sum_ext = {alu_a[DATA_W-1], alu_a} + {alu_b[DATA_W-1], alu_b};
    assign dif_ext = {alu_a[DATA_W-1], alu_a} - {alu_b[DATA_W-1], alu_b};
    assign add_ovf = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];
    assign sub_ovf = dif_ext[DATA_W] ^ dif_ext[DATA_W-1];
    assign ea      = sum_ext[DATA_W-1:0];

    assign is_load  = (det_type == DET_LOAD);
    assign is_store = (det_type == DET_STORE);

    // A zero lower bound can never be violated; skip the always-false compare.
    generate
        if (DM_LO == '0) begin : g_no_lo
            assign below_lo = 1'b0;
        end else begin : g_lo
            assign below_lo = (ea < DM_LO);
        end
    endgenerate

    assign above_hi = (ea > DM_HI);

    always_comb begin
        misaligned = 1'b0;
        case (acc_size)
            2'd1:    misaligned = ea[0];
            2'd2:    misaligned = (ea[1:0] != 2'b00);
            2'd3:    misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    assign arith_ovf  = ((det_type == DET_ADD) && add_ovf) || ((det_type == DET_SUB) && sub_ovf);
    assign addr_fault = (is_load || is_store) && (add_ovf || below_lo || above_hi || misaligned);

    always_comb begin
        merged_exc  = 1'b0;
        merged_code = '0;
        merged_ovf  = 1'b0;
        if (in_exc) begin
            merged_exc  = 1'b1;
            merged_code = in_code;
        end else if (arith_ovf) begin
            merged_exc  = 1'b1;
            merged_code = OV_CODE;
            merged_ovf  = 1'b1;
        end else if (addr_fault) begin
            merged_exc  = 1'b1;
            merged_code = is_load ? ADEL_CODE : ADES_CODE;
        end
    end

    assign e_exc      = in_exc || arith_ovf || addr_fault;
    assign commit_ovf = !flush && !stall && merged_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_exc   <= 1'b0;
            m_code  <= '0;
            m_ovf   <= 1'b0;
            m_pc    <= '0;
            m_bd    <= 1'b0;
            ovf_cnt <= '0;
        end else begin
            if (flush) begin
                m_exc  <= 1'b0;
                m_code <= '0;
                m_ovf  <= 1'b0;
                m_pc   <= '0;
                m_bd   <= 1'b0;
            end else if (!stall) begin
                m_exc  <= merged_exc;
                m_code <= merged_code;
                m_ovf  <= merged_ovf;
                m_pc   <= in_pc;
                m_bd   <= in_bd;
            end
            if (cnt_clr) begin
                ovf_cnt <= '0;
            end else if (commit_ovf && (ovf_cnt != '1)) begin
                ovf_cnt <= ovf_cnt + CNT_W'(1);
            end
        end
    end

endmodule
